// File: rtl/count_chk_pkg.sv
// count_chk_pkg
// Shared types and helpers for the counter sequence checker.
//   state_t        : checker FSM states
//   ST_W           : encoded width of state_t
//   next_expected  : value a well-behaved counter should show after prev,
//                    wrapped modulo 2^width
package count_chk_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2,
        LOST = 2'd3
    } state_t;

    // Works on a 32-bit container so any WIDTH up to 32 can share it; the
    // caller truncates the result back to its own width.
    function automatic logic [31:0] next_expected(
        input logic [31:0] prev,
        input logic        dir_down,
        input int          width
    );
        logic [31:0] mask;
        logic [31:0] raw;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        raw  = dir_down ? (prev - 32'h1) : (prev + 32'h1);
        return raw & mask;
    endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high clear
//   inc   : add one this cycle (ignored once saturated)
//   q     : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker
// Passive monitor for a free-running up/down counter. Checks that every
// valid sample moves by exactly one step (modulo 2^WIDTH), locks after a
// run of good steps, then flags and counts deviations and legal wraps.
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high
//   sample_valid : q_in is meaningful this cycle
//   q_in         : monitored counter value
//   locked       : checker is in LOCK
//   err_pulse    : one-cycle pulse per mismatch seen while locked
//   err_count    : saturating mismatch count
//   wrap_count   : saturating count of legal wraps seen while locked
//   last_q       : most recently accepted sample
//
// state | meaning
// IDLE  | no sample seen since reset
// SYNC  | counting consecutive good steps towards lock
// LOCK  | locked; deviations are errors
// LOST  | just lost lock; next sample re-seeds the sync run
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DIR_DOWN   = 1,
    parameter int SYNC_LEN   = 2,
    parameter int ALLOW_HOLD = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] q_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] last_q
);

    localparam logic [2:0]       SYNC_TGT = 3'(SYNC_LEN);
    localparam logic             HOLD_OK  = (ALLOW_HOLD != 0);
    localparam logic             DOWN     = (DIR_DOWN != 0);
    localparam logic [WIDTH-1:0] Q_MAX    = {WIDTH{1'b1}};

    state_t           state, state_next;
    logic [2:0]       good_run, good_run_next;
    logic [WIDTH-1:0] last_q_next;
    logic [WIDTH-1:0] expected;
    logic             is_step, is_hold, is_wrap;
    logic             err_next, wrap_inc;

    assign expected = WIDTH'(next_expected(32'(last_q), DOWN, WIDTH));
    assign is_step  = (q_in == expected);
    assign is_hold  = HOLD_OK && (q_in == last_q);
    // A good step out of the extreme value is the wrap.
    assign is_wrap  = DOWN ? (last_q == '0) : (last_q == Q_MAX);

    always_comb begin
        state_next    = state;
        good_run_next = good_run;
        last_q_next   = last_q;
        err_next      = 1'b0;
        wrap_inc      = 1'b0;
        if (sample_valid) begin
            case (state)
                IDLE: begin
                    last_q_next   = q_in;
                    good_run_next = '0;
                    state_next    = SYNC;
                end
                SYNC: begin
                    if (is_step) begin
                        last_q_next   = q_in;
                        good_run_next = good_run + 3'd1;
                        if ((good_run + 3'd1) >= SYNC_TGT) begin
                            state_next = LOCK;
                        end
                    end else if (!is_hold) begin
                        // Re-seed the run from this sample without counting an error.
                        last_q_next   = q_in;
                        good_run_next = '0;
                    end
                end
                LOCK: begin
                    if (is_step) begin
                        last_q_next = q_in;
                        wrap_inc    = is_wrap;
                    end else if (!is_hold) begin
                        last_q_next = q_in;
                        err_next    = 1'b1;
                        state_next  = LOST;
                    end
                end
                LOST: begin
                    last_q_next   = q_in;
                    good_run_next = '0;
                    state_next    = SYNC;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            good_run  <= '0;
            last_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            good_run  <= good_run_next;
            last_q    <= last_q_next;
            locked    <= (state_next == LOCK);
            err_pulse <= err_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_next),
        .q     (err_count)
    );

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc),
        .q     (wrap_count)
    );

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker
// Three checker instances share one stimulus stream:
//   dut_a : default parameters
//   dut_h : ALLOW_HOLD = 0
//   dut_s : CNT_W = 2 (saturation)
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [3:0] q_in = 4'd0;

    logic       a_locked, a_err_pulse;
    logic [7:0] a_err_count, a_wrap_count;
    logic [3:0] a_last_q;
    logic       h_locked, h_err_pulse;
    logic [7:0] h_err_count, h_wrap_count;
    logic [3:0] h_last_q;
    logic       s_locked, s_err_pulse;
    logic [1:0] s_err_count, s_wrap_count;
    logic [3:0] s_last_q;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    count_seq_checker dut_a (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .q_in(q_in),
        .locked(a_locked), .err_pulse(a_err_pulse), .err_count(a_err_count),
        .wrap_count(a_wrap_count), .last_q(a_last_q)
    );

    count_seq_checker #(.ALLOW_HOLD(0)) dut_h (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .q_in(q_in),
        .locked(h_locked), .err_pulse(h_err_pulse), .err_count(h_err_count),
        .wrap_count(h_wrap_count), .last_q(h_last_q)
    );

    count_seq_checker #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .q_in(q_in),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
        .wrap_count(s_wrap_count), .last_q(s_last_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; the rising edge in between consumes
    // them, so outputs read on return are the response to this sample.
    task automatic drive(input logic v, input logic [3:0] q);
        sample_valid = v;
        q_in         = q;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 4'd5);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // reset state, all instances
        chk("rst_a_locked", a_locked, 0);
        chk("rst_a_pulse", a_err_pulse, 0);
        chk("rst_a_err", a_err_count, 0);
        chk("rst_a_wrap", a_wrap_count, 0);
        chk("rst_a_lastq", a_last_q, 0);
        chk("rst_h_all", {h_locked, h_err_pulse, h_err_count, h_wrap_count, h_last_q}, 0);
        chk("rst_s_all", {s_locked, s_err_pulse, s_err_count, s_wrap_count, s_last_q}, 0);

        // lock on 5,4,3
        drive(1'b1, 4'd5);
        chk("sync5_locked", a_locked, 0);
        chk("sync5_lastq", a_last_q, 5);
        drive(1'b1, 4'd4);
        chk("sync4_locked", a_locked, 0);
        drive(1'b1, 4'd3);
        chk("lock3_locked", a_locked, 1);
        chk("lock3_err", a_err_count, 0);
        drive(1'b1, 4'd2);
        chk("lock2_locked", a_locked, 1);
        chk("lock2_lastq", a_last_q, 2);

        // wrap 0 -> 15
        drive(1'b1, 4'd1);
        drive(1'b1, 4'd0);
        chk("pre_wrap", a_wrap_count, 0);
        drive(1'b1, 4'd15);
        chk("wrap_count", a_wrap_count, 1);
        chk("wrap_pulse", a_err_pulse, 0);
        drive(1'b1, 4'd14);
        chk("post_wrap", a_wrap_count, 1);
        chk("post_wrap_locked", a_locked, 1);

        // walk down to 9, then skip to 7
        for (int v = 13; v >= 9; v--) drive(1'b1, 4'(v));
        chk("at9_locked", a_locked, 1);
        drive(1'b1, 4'd7);
        chk("skip_pulse", a_err_pulse, 1);
        chk("skip_err", a_err_count, 1);
        chk("skip_locked", a_locked, 0);
        chk("skip_lastq", a_last_q, 7);
        drive(1'b1, 4'd6);
        chk("skip_pulse_once", a_err_pulse, 0);
        chk("lost_to_sync", a_locked, 0);
        drive(1'b1, 4'd5);
        chk("resync5", a_locked, 0);
        drive(1'b1, 4'd4);
        chk("relock4", a_locked, 1);
        chk("relock_err", a_err_count, 1);

        // holds: legal for dut_a, mismatch for dut_h
        do_reset();
        drive(1'b1, 4'd5);
        drive(1'b1, 4'd4);
        drive(1'b1, 4'd3);
        chk("hold_pre_a", a_locked, 1);
        chk("hold_pre_h", h_locked, 1);
        drive(1'b1, 4'd3);
        chk("hold1_a_pulse", a_err_pulse, 0);
        chk("hold1_h_pulse", h_err_pulse, 1);
        drive(1'b1, 4'd3);
        drive(1'b1, 4'd2);
        chk("hold_a_err", a_err_count, 0);
        chk("hold_a_locked", a_locked, 1);
        chk("hold_a_lastq", a_last_q, 2);
        chk("hold_h_err", h_err_count, 1);
        chk("hold_h_locked", h_locked, 0);

        // invalid cycle in the middle of a good step
        do_reset();
        drive(1'b1, 4'd10);
        drive(1'b1, 4'd9);
        drive(1'b1, 4'd8);
        chk("gap_pre_locked", a_locked, 1);
        drive(1'b0, 4'd3);
        chk("gap_lastq", a_last_q, 8);
        chk("gap_locked", a_locked, 1);
        chk("gap_pulse", a_err_pulse, 0);
        drive(1'b1, 4'd7);
        chk("gap_step_lastq", a_last_q, 7);
        chk("gap_step_err", a_err_count, 0);
        chk("gap_step_locked", a_locked, 1);

        // repeated mismatch/relock: dut_s saturates at 3
        do_reset();
        drive(1'b1, 4'd5);
        drive(1'b1, 4'd4);
        drive(1'b1, 4'd3);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd9);
            chk("sat_s_err", s_err_count, (i < 3) ? i + 1 : 3);
            drive(1'b1, 4'd8);
            drive(1'b1, 4'd7);
            drive(1'b1, 4'd6);
            chk("sat_relock", s_locked, 1);
        end
        chk("sat_a_err", a_err_count, 4);
        chk("sat_s_final", s_err_count, 3);

        // reset wins over a valid sample
        reset = 1'b1;
        drive(1'b1, 4'd5);
        reset = 1'b0;
        chk("rst2_s_err", s_err_count, 0);
        chk("rst2_a_err", a_err_count, 0);
        chk("rst2_locked", a_locked, 0);
        chk("rst2_lastq", a_last_q, 0);
        drive(1'b1, 4'd5);
        chk("rst2_first_lastq", a_last_q, 5);
        drive(1'b1, 4'd4);
        chk("rst2_sync", a_locked, 0);
        drive(1'b1, 4'd3);
        chk("rst2_relock", a_locked, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Passive monitor for the 4-bit counter family; samples a counter's q output and checks that each step decrements (or increments) by exactly one, wrapping modulo 2^WIDTH.
- Locks after a run of good steps, then flags every deviation, counts errors and wraps, and reports lock status.
- Sits beside any Count4Down/up-counter instance as an in-design checker; also serves as a self-checking bench component.

Parameters:
- WIDTH, 4, width of monitored count.
- DIR_DOWN, 1, 1 = expect prev-1 each step; 0 = expect prev+1.
- SYNC_LEN, 2, consecutive good steps required to enter LOCK (range 1..7).
- ALLOW_HOLD, 1, 1 = sample equal to previous is a legal stall (no error, no advance); 0 = hold counts as mismatch.
- CNT_W, 8, width of err_count and wrap_count.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous, active-high reset.
- sample_valid, input, 1, q_in is valid this cycle.
- q_in, input, WIDTH, monitored counter value.
- locked, output, 1, checker is in LOCK.
- err_pulse, output, 1, one-cycle pulse per detected mismatch while locked.
- err_count, output, CNT_W, saturating mismatch count.
- wrap_count, output, CNT_W, saturating count of legal wraps seen while locked.
- last_q, output, WIDTH, most recently accepted sample.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high; all state updates on rising clk only.
- Reset values: state = IDLE, locked = 0, err_pulse = 0, err_count = 0, wrap_count = 0, last_q = 0, good_run = 0. Reset wins over sample_valid in the same cycle.
- All outputs are registered; every response appears on the cycle after the sample that caused it.
- Cycles with sample_valid = 0 change nothing. err_pulse is cleared every cycle unless set by that cycle's sample.
- expected = last_q - 1 mod 2^WIDTH if DIR_DOWN, else last_q + 1 mod 2^WIDTH. Arithmetic is truncated to WIDTH bits.
- IDLE: first valid sample -> last_q <= q_in, good_run <= 0, go SYNC.
- SYNC, valid sample:
  - q_in == expected -> good_run++, last_q <= q_in. When good_run reaches SYNC_LEN -> go LOCK and assert locked.
  - hold (q_in == last_q, ALLOW_HOLD = 1) -> no change.
  - otherwise -> good_run <= 0, last_q <= q_in, stay SYNC. No error is counted.
- LOCK, valid sample:
  - q_in == expected -> last_q <= q_in. If it is a wrap (down: 0 -> max; up: max -> 0), wrap_count++ saturating.
  - hold, when allowed -> no change.
  - mismatch -> err_pulse = 1, err_count++ saturating, last_q <= q_in, go LOST.
- LOST: locked = 0. Next valid sample -> last_q <= q_in, good_run <= 0, go SYNC. A LOST cycle with a valid sample never raises a further error.
- Saturation: err_count and wrap_count stick at 2^CNT_W - 1.
- Reset mid-run: all counters clear and lock is lost on the next edge; the checker resynchronises from IDLE.

Decomposition:
- Package count_chk_pkg:
  - state enum (IDLE, SYNC, LOCK, LOST).
  - function next_expected(prev, dir), parameterised on WIDTH.
  - constant ST_W = 2.
- One natural sub-module, sat_counter (parameter W; ports clk, reset, inc, q), instantiated twice, for err_count and wrap_count.
- The FSM and compare logic stay in count_seq_checker.

Test Plan:
- Reset held, then valid down sequence 5,4,3,2 on consecutive cycles (defaults) -> locked = 1 on the cycle after sample 3; err_count = 0.
- Locked, feed 1,0,15,14 -> wrap_count = 1 one cycle after 15; no err_pulse.
- Locked at 9, feed 7 -> err_pulse high for exactly one cycle; err_count = 1; locked = 0. Then feed 6,5,4 -> relocks after 4; err_count stays 1.
- Locked at 3, feed 3,3,2 with ALLOW_HOLD = 1 -> no error, remains locked. Same stimulus with ALLOW_HOLD = 0 -> err_count = 1.
- sample_valid toggled 1,0,1 on the sequence 8,x,7 -> still treated as a good step; the invalid cycle changes no output.
- CNT_W = 2, four forced mismatch/relock cycles -> err_count saturates at 3. Then reset pulsed during a sample -> all outputs 0 the next cycle, and the first valid sample afterwards moves the FSM to SYNC.
